// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bundle
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             d_bit;
  logic             d_bit_valid;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, d_bit, d_bit_valid, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, d_bit, d_bit_valid, ovf
  );
endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor x - y - bi
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);
  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial D = A - B - Bin, LSB first; SERIAL_SUB_OVF_EN adds signed overflow
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d, bout_q, bout_d, d_bit_q, d_bit_d;
  logic             diff, brw;
  logic             accept, last_shift;

  full_subtractor u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bi   (borrow_q),
    .diff (diff),
    .bo   (brw)
  );

  assign accept     = (state_q == ST_IDLE) && bus.start;
  assign last_shift = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    d_bit_d  = d_bit_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sa_d     = bus.a;
          sb_d     = bus.b;
          borrow_d = bus.bin;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        d_bit_d  = diff;
        res_d    = {diff, res_q[WIDTH-1:1]};
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        borrow_d = brw;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Result registers load on the way into DONE so d/bout stay frozen through IDLE.
          d_d     = {diff, res_q[WIDTH-1:1]};
          bout_d  = brw;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      d_bit_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      d_bit_q  <= d_bit_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
      ovf_q   <= 1'b0;
    end else if (last_shift) begin
      ovf_q   <= (a_msb_q != b_msb_q) && (diff != a_msb_q);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.d_bit_valid = (state_q == ST_SHIFT);
  assign bus.d_bit       = d_bit_q;
  assign bus.d           = d_q;
  assign bus.bout        = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed table and corner sequences for serial_subtractor
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the caller at the negedge where done is seen (lat = cycles after acceptance, -1 on timeout).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      output logic [7:0] dbits, output int lat);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.bin   = bin;
    @(negedge clk);
    bus8.start = 1'b0;
    lat   = -1;
    dbits = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i >= 2 && i <= 9) dbits[i-2] = bus8.d_bit;
      if (bus8.done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic exp_ovf(input logic v);
`ifdef SERIAL_SUB_OVF_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  initial begin
    logic [7:0] dbits;
    int         lat;
    int         p1, p2;
    bit         seen;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus8.busy, bus8.done, bus8.d_bit_valid, bus8.d_bit,
                                bus8.bout, bus8.ovf, bus8.d}), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run8(vecs[k].a, vecs[k].b, vecs[k].bin, dbits, lat);
      check($sformatf("latency[%0d]", k), 32'(lat), 32'd9);
      check($sformatf("d[%0d]", k), 32'(bus8.d), 32'(vecs[k].d));
      check($sformatf("bout[%0d]", k), 32'(bus8.bout), 32'(vecs[k].bout));
      check($sformatf("ovf[%0d]", k), 32'(bus8.ovf), 32'(exp_ovf(vecs[k].ovf)));
      check($sformatf("d_bits[%0d]", k), 32'(dbits), 32'(vecs[k].d));
    end

    // Second start mid-SHIFT must be dropped.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin bus8.start = 1'b1; bus8.a = 8'hFF; end
      if (i == 4) bus8.start = 1'b0;
      if (bus8.done) begin lat = i; break; end
      @(negedge clk);
    end
    check("ignored_start_latency", 32'(lat), 32'd9);
    check("ignored_start_d", 32'(bus8.d), 32'h0F);
    @(negedge clk);
    check("ignored_start_idle", 32'(bus8.busy), 32'd0);

    // Held start restarts on the first IDLE cycle: done pulses WIDTH+2 apart.
    bus8.start = 1'b1; bus8.a = 8'h20; bus8.b = 8'h01; bus8.bin = 1'b0;
    p1 = -1; p2 = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (p1 < 0) p1 = i;
        else if (p2 < 0) p2 = i;
      end
    end
    bus8.start = 1'b0;
    check("held_first_done", 32'(p1), 32'd9);
    check("held_second_done", 32'(p2), 32'd19);
    check("held_d", 32'(bus8.d), 32'h1F);

    // Reset during the 5th SHIFT cycle.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h11; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", 32'({bus8.busy, bus8.done, bus8.d_bit_valid, bus8.d_bit,
                                   bus8.bout, bus8.ovf, bus8.d}), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) seen = 1'b1;
    end
    check("midreset_no_done", 32'(seen), 32'd0);
    run8(8'h05, 8'h03, 1'b0, dbits, lat);
    check("recover_latency", 32'(lat), 32'd9);
    check("recover_d", 32'({bus8.bout, bus8.d}), 32'h002);

    // WIDTH=4 exhaustive against (a - b - bin) mod 32.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          int   r;
          logic ov;
          @(negedge clk);
          bus4.start = 1'b1;
          bus4.a     = ai[3:0];
          bus4.b     = bi[3:0];
          bus4.bin   = ci[0];
          @(negedge clk);
          bus4.start = 1'b0;
          lat = -1;
          for (int i = 1; i <= 10; i++) begin
            if (bus4.done) begin lat = i; break; end
            @(negedge clk);
          end
          r  = (ai - bi - ci) & 31;
          ov = exp_ovf((ai[3] != bi[3]) && (r[3] != ai[3]));
          check($sformatf("w4 %0d-%0d-%0d", ai, bi, ci),
                32'({lat == 5, bus4.ovf, bus4.bout, bus4.d}),
                32'({1'b1, ov, r[4:0]}));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
